spi_mem_responder: RTL and testbench

SPI mode‑0 responder that emulates a serial RAM/flash device on the external memory SPI link: the device end of the link that the memory bus drives through `sclk`/`mosi`/`cs`. It oversamples the SPI pins in the system clock domain, decodes READ (0x03) and WRITE (0x02) command frames and serves them from an internal byte array. It is used as an on‑chip stand‑in for the external memory in integration benches and FPGA builds. A host‑side port allows the array to be preloaded and inspected.

---
 rtl/spi_mem_responder_if.sv | 28 ++
 rtl/spi_mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_spi_mem_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_responder_if.sv
// Pin and host-port bundle for spi_mem_responder: the SPI link plus the preload/inspect port.
interface spi_mem_responder_if #(
    parameter int MEM_BYTES = 256
);
    localparam int AW = $clog2(MEM_BYTES);

    logic          sclk;
    logic          mosi;
    logic          cs_n;
    logic          miso;
    logic          miso_oe;
    logic          busy;
    logic          cmd_err;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic [7:0]    host_rdata;

    modport master (
        output sclk, mosi, cs_n, host_we, host_addr, host_wdata,
        input  miso, miso_oe, busy, cmd_err, host_rdata
    );

    modport slave (
        input  sclk, mosi, cs_n, host_we, host_addr, host_wdata,
        output miso, miso_oe, busy, cmd_err, host_rdata
    );
endinterface

// File: rtl/spi_mem_responder.sv
// SPI mode-0 serial RAM/flash stand-in serving READ (0x03) and WRITE (0x02) from a byte array.
// WRITE is decoded only when SPI_MEM_RESP_WRITE_EN is defined; otherwise the array is read-only over SPI.
module spi_mem_responder #(
    parameter int MEM_BYTES  = 256,
    parameter int ADDR_BYTES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_mem_responder_if.slave   bus
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = 5;
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BYTES * 8 - 1);
    localparam logic [CW-1:0] BYTE_LAST = CW'(7);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_RD, S_WR, S_IGNORE} state_t;

    logic [7:0] mem [MEM_BYTES];

    logic [2:0] sclk_sr;
    logic [2:0] cs_sr;
    logic [1:0] mosi_sr;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

    state_t        state, state_d;
    logic [CW-1:0] bit_cnt, bit_cnt_d;
    logic [AW-1:0] addr, addr_d;
    logic [7:0]    sh_in, sh_in_d, sh_out, sh_out_d, byte_in, rd_byte, spi_wdata;
    logic          rd_mode, rd_mode_d, spi_we;
    logic          miso_q, miso_d, oe_q, oe_d, busy_q, err_q, err_d;
    logic [7:0]    host_rdata_q;

    // Synchronisers are left unreset so they keep tracking the pins; a frame
    // already low across reset release then produces no cs_n fall.
    always_ff @(posedge clk) begin
        sclk_sr <= {sclk_sr[1:0], bus.sclk};
        cs_sr   <= {cs_sr[1:0], bus.cs_n};
        mosi_sr <= {mosi_sr[0], bus.mosi};
    end

    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign cs_fall   = ~cs_sr[1] & cs_sr[2];
    assign cs_rise   = cs_sr[1] & ~cs_sr[2];
    assign mosi_s    = mosi_sr[1];
    assign byte_in   = {sh_in[6:0], mosi_s};
    assign rd_byte   = mem[addr];

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        addr_d    = addr;
        sh_in_d   = sh_in;
        sh_out_d  = sh_out;
        rd_mode_d = rd_mode;
        miso_d    = miso_q;
        oe_d      = oe_q;
        err_d     = 1'b0;
        spi_we    = 1'b0;
        spi_wdata = byte_in;
        case (state)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d   = S_CMD;
                    bit_cnt_d = '0;
                end
            end
            S_CMD: begin
                if (sclk_rise) begin
                    sh_in_d   = byte_in;
                    bit_cnt_d = bit_cnt + CW'(1);
                    if (bit_cnt == BYTE_LAST) begin
                        bit_cnt_d = '0;
                        if (byte_in == 8'h03) begin
                            state_d   = S_ADDR;
                            rd_mode_d = 1'b1;
                        end
`ifdef SPI_MEM_RESP_WRITE_EN
                        else if (byte_in == 8'h02) begin
                            state_d   = S_ADDR;
                            rd_mode_d = 1'b0;
                        end
`endif
                        else begin
                            err_d   = 1'b1;
                            state_d = S_IGNORE;
                        end
                    end
                end
            end
            S_ADDR: begin
                // Only the low AW bits survive the shift, dropping the unused high address bits.
                if (sclk_rise) begin
                    addr_d    = {addr[AW-2:0], mosi_s};
                    bit_cnt_d = bit_cnt + CW'(1);
                    if (bit_cnt == ADDR_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = rd_mode ? S_RD : S_WR;
                    end
                end
            end
            S_RD: begin
                if (sclk_fall) begin
                    if (bit_cnt == '0) begin
                        miso_d    = rd_byte[7];
                        sh_out_d  = {rd_byte[6:0], 1'b0};
                        oe_d      = 1'b1;
                        bit_cnt_d = CW'(1);
                    end else begin
                        miso_d    = sh_out[7];
                        sh_out_d  = {sh_out[6:0], 1'b0};
                        bit_cnt_d = bit_cnt + CW'(1);
                        if (bit_cnt == BYTE_LAST) begin
                            bit_cnt_d = '0;
                            addr_d    = addr + AW'(1);
                        end
                    end
                end
            end
            S_WR: begin
                if (sclk_rise) begin
                    sh_in_d   = byte_in;
                    bit_cnt_d = bit_cnt + CW'(1);
                    if (bit_cnt == BYTE_LAST) begin
                        spi_we    = 1'b1;
                        addr_d    = addr + AW'(1);
                        bit_cnt_d = '0;
                    end
                end
            end
            default: ;
        endcase
        if (cs_rise) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            miso_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            bit_cnt      <= '0;
            addr         <= '0;
            sh_in        <= '0;
            sh_out       <= '0;
            rd_mode      <= 1'b0;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state        <= state_d;
            bit_cnt      <= bit_cnt_d;
            addr         <= addr_d;
            sh_in        <= sh_in_d;
            sh_out       <= sh_out_d;
            rd_mode      <= rd_mode_d;
            miso_q       <= miso_d;
            oe_q         <= oe_d;
            busy_q       <= ~cs_sr[1];
            err_q        <= err_d;
            host_rdata_q <= mem[bus.host_addr];
        end
    end

    // SPI write is issued last so it wins a same-address collision with the host.
    always_ff @(posedge clk) begin
        if (bus.host_we) mem[bus.host_addr] <= bus.host_wdata;
        if (spi_we)      mem[addr]          <= spi_wdata;
    end

    assign bus.miso       = miso_q;
    assign bus.miso_oe    = oe_q;
    assign bus.busy       = busy_q;
    assign bus.cmd_err    = err_q;
    assign bus.host_rdata = host_rdata_q;
endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: table of read frames plus hand-written write/abort/error frames.
module tb_spi_mem_responder;
    localparam int HALF = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   err_cycles = 0;

    always #5 clk = ~clk;

    spi_mem_responder_if #(.MEM_BYTES(256)) bus ();

    spi_mem_responder #(.MEM_BYTES(256), .ADDR_BYTES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) if (bus.cmd_err) err_cycles++;

    typedef struct {
        logic [23:0] addr;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [5];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        bus.host_addr  = a;
        bus.host_wdata = d;
        bus.host_we    = 1'b1;
        tick(1);
        bus.host_we    = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] a, output logic [7:0] d);
        bus.host_addr = a;
        tick(1);
        d = bus.host_rdata;
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                            output logic oe_any, output logic oe_all);
        rx = '0;
        oe_any = 1'b0;
        oe_all = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = tx[7-i];
            tick(HALF);
            rx[7-i] = bus.miso;
            oe_any  = oe_any | bus.miso_oe;
            oe_all  = oe_all & bus.miso_oe;
            bus.sclk = 1'b1;
            tick(HALF);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        bus.cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic frame_end();
        tick(HALF);
        bus.cs_n = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic do_read(input logic [23:0] a, input int nbytes, output logic [31:0] data,
                           output logic oe_pre_any, output logic oe_data_all);
        logic [7:0] rx;
        logic       any, all;
        data = '0;
        oe_pre_any  = 1'b0;
        oe_data_all = 1'b1;
        frame_begin();
        spi_xfer(8'h03, 8, rx, any, all);   oe_pre_any = oe_pre_any | any;
        spi_xfer(a[23:16], 8, rx, any, all); oe_pre_any = oe_pre_any | any;
        spi_xfer(a[15:8], 8, rx, any, all);  oe_pre_any = oe_pre_any | any;
        spi_xfer(a[7:0], 8, rx, any, all);   oe_pre_any = oe_pre_any | any;
        for (int b = 0; b < nbytes; b++) begin
            spi_xfer(8'h00, 8, rx, any, all);
            data = {data[23:0], rx};
            oe_data_all = oe_data_all & all;
        end
        frame_end();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] data;
        logic        pre, dall, any, all;
        logic [7:0]  rx, rd;
        int          e0;

        vecs[0] = '{24'h000010, 16'hDEAD};
        vecs[1] = '{24'h000012, 16'hBEEF};
        vecs[2] = '{24'h0000FF, 16'h5AA5};
        vecs[3] = '{24'h0ABC12, 16'hBEEF};
        vecs[4] = '{24'h000000, 16'hA53C};

        bus.sclk = 1'b0; bus.mosi = 1'b0; bus.cs_n = 1'b1;
        bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        tick(6);
        check("rst_miso", 32'(bus.miso), 32'd0);
        check("rst_oe", 32'(bus.miso_oe), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
        check("rst_host_rdata", 32'(bus.host_rdata), 32'd0);
        rst = 1'b0;
        tick(2);

        host_write(8'h10, 8'hDE); host_write(8'h11, 8'hAD);
        host_write(8'h12, 8'hBE); host_write(8'h13, 8'hEF);
        host_write(8'hFF, 8'h5A); host_write(8'h00, 8'hA5);
        host_write(8'h01, 8'h3C);
        host_write(8'h20, 8'h11); host_write(8'h21, 8'h22);
        host_write(8'h22, 8'h33);
        host_read(8'h12, rd);
        check("host_rd_12", 32'(rd), 32'hBE);

        // 32-bit read with busy observed mid-frame
        frame_begin();
        check("busy_in_frame", 32'(bus.busy), 32'd1);
        spi_xfer(8'h03, 8, rx, any, all);  pre = any;
        spi_xfer(8'h00, 8, rx, any, all);  pre = pre | any;
        spi_xfer(8'h00, 8, rx, any, all);  pre = pre | any;
        spi_xfer(8'h10, 8, rx, any, all);  pre = pre | any;
        data = '0; dall = 1'b1;
        for (int b = 0; b < 4; b++) begin
            spi_xfer(8'h00, 8, rx, any, all);
            data = {data[23:0], rx};
            dall = dall & all;
        end
        frame_end();
        check("read32_data", data, 32'hDEADBEEF);
        check("read32_oe_pre", 32'(pre), 32'd0);
        check("read32_oe_data", 32'(dall), 32'd1);
        check("oe_after_frame", 32'(bus.miso_oe), 32'd0);
        check("busy_after_frame", 32'(bus.busy), 32'd0);

        e0 = err_cycles;
        for (int i = 0; i < 5; i++) begin
            do_read(vecs[i].addr, 2, data, pre, dall);
            check($sformatf("vec%0d_data", i), data, {16'h0, vecs[i].exp});
            check($sformatf("vec%0d_oe_pre", i), 32'(pre), 32'd0);
            check($sformatf("vec%0d_oe_data", i), 32'(dall), 32'd1);
        end
        check("no_err_on_reads", 32'(err_cycles - e0), 32'd0);

        // unsupported command: one cmd_err cycle, no drive for the rest of the frame
        e0 = err_cycles;
        frame_begin();
        spi_xfer(8'h9F, 8, rx, any, all);  pre = any;
        for (int b = 0; b < 3; b++) begin
            spi_xfer(8'h00, 8, rx, any, all);
            pre = pre | any;
        end
        frame_end();
        check("bad_cmd_err_cycles", 32'(err_cycles - e0), 32'd1);
        check("bad_cmd_oe", 32'(pre), 32'd0);
        do_read(24'h000013, 1, data, pre, dall);
        check("read_after_bad", data, 32'hEF);

        // abort after 12 address bits
        frame_begin();
        spi_xfer(8'h03, 8, rx, any, all);
        spi_xfer(8'h00, 8, rx, any, all);
        spi_xfer(8'hF0, 4, rx, any, all);
        frame_end();
        do_read(24'h000001, 1, data, pre, dall);
        check("abort_then_read", data, 32'h3C);
        check("abort_then_read_oe", 32'(dall), 32'd1);

        // write frame with a trailing partial byte
        e0 = err_cycles;
        frame_begin();
        spi_xfer(8'h02, 8, rx, any, all);  pre = any;
        spi_xfer(8'h00, 8, rx, any, all);  pre = pre | any;
        spi_xfer(8'h00, 8, rx, any, all);  pre = pre | any;
        spi_xfer(8'h20, 8, rx, any, all);  pre = pre | any;
        spi_xfer(8'h12, 8, rx, any, all);  pre = pre | any;
        spi_xfer(8'h34, 8, rx, any, all);  pre = pre | any;
        spi_xfer(8'hF0, 4, rx, any, all);  pre = pre | any;
        frame_end();
        check("wr_frame_oe", 32'(pre), 32'd0);
`ifdef SPI_MEM_RESP_WRITE_EN
        check("wr_err_cycles", 32'(err_cycles - e0), 32'd0);
        host_read(8'h20, rd); check("wr_mem20", 32'(rd), 32'h12);
        host_read(8'h21, rd); check("wr_mem21", 32'(rd), 32'h34);
        host_read(8'h22, rd); check("wr_mem22", 32'(rd), 32'h33);
`else
        check("wr_err_cycles", 32'(err_cycles - e0), 32'd1);
        host_read(8'h20, rd); check("ro_mem20", 32'(rd), 32'h11);
        host_read(8'h21, rd); check("ro_mem21", 32'(rd), 32'h22);
        host_read(8'h22, rd); check("ro_mem22", 32'(rd), 32'h33);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
